// File: rtl/spi_ram_master_if.sv
// Host-side command/response bundle for spi_ram_master.
// seq_err is present only when SPI_RAM_MASTER_SEQCHK_EN is defined.
interface spi_ram_master_if;
  logic       cmd_valid;
  logic [9:0] cmd_data;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
`ifdef SPI_RAM_MASTER_SEQCHK_EN
  logic       seq_err;

  modport master (output cmd_valid, cmd_data,
                  input  cmd_ready, rsp_valid, rsp_data, busy, seq_err);
  modport slave  (input  cmd_valid, cmd_data,
                  output cmd_ready, rsp_valid, rsp_data, busy, seq_err);
`else
  modport master (output cmd_valid, cmd_data,
                  input  cmd_ready, rsp_valid, rsp_data, busy);
  modport slave  (input  cmd_valid, cmd_data,
                  output cmd_ready, rsp_valid, rsp_data, busy);
`endif
endinterface

// File: rtl/spi_ram_master.sv
// SPI master for the SPI-slave/RAM subsystem: frames 10-bit host commands, returns read-data bytes.
// Define SPI_RAM_MASTER_SEQCHK_EN to reject read-data commands not preceded by a read address.
module spi_ram_master #(
  parameter int TURNAROUND = 2,
  parameter int IDLE_GAP   = 1
) (
  input  logic            clk,
  input  logic            rst,
  spi_ram_master_if.slave host,
  output logic            SS_n,
  output logic            MOSI,
  input  logic            MISO
);

  localparam int LEN_MAX = (TURNAROUND > IDLE_GAP) ? ((TURNAROUND > 10) ? TURNAROUND : 10)
                                                   : ((IDLE_GAP > 10) ? IDLE_GAP : 10);
  localparam int CNT_W = $clog2(LEN_MAX);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(9);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURNAROUND - 1);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(7);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IDLE_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_TURN    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_GAP     = 3'd5,
    ST_REJECT  = 3'd6
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [9:0]       shift_r;
  logic [1:0]       op_r;
  logic [6:0]       cap_r;
  logic             accept_s;
  logic             reject_s;
  logic             shift_done_s;
  logic             cap_done_s;

  logic             ss_n_r, mosi_r, cmd_ready_r, rsp_valid_r, busy_r;
  logic [7:0]       rsp_data_r;
  logic             ss_n_s, mosi_s, cmd_ready_s, rsp_valid_s, busy_s;

  assign accept_s     = host.cmd_valid && cmd_ready_r;
  assign shift_done_s = (state_r == ST_SHIFT) && (cnt_r == SHIFT_LAST);
  assign cap_done_s   = (state_r == ST_CAPTURE) && (cnt_r == CAP_LAST);

`ifdef SPI_RAM_MASTER_SEQCHK_EN
  logic rd_addr_set_r;
  logic seq_err_r;

  assign reject_s     = (host.cmd_data[9:8] == 2'b11) && !rd_addr_set_r;
  assign host.seq_err = seq_err_r;

  // Tracks whether a read address has been framed since the last read-data frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_set_r <= 1'b0;
      seq_err_r     <= 1'b0;
    end else begin
      seq_err_r <= (next_state_s == ST_REJECT);
      if (shift_done_s && (op_r == 2'b10)) begin
        rd_addr_set_r <= 1'b1;
      end else if (cap_done_s) begin
        rd_addr_set_r <= 1'b0;
      end
    end
  end
`else
  assign reject_s = 1'b0;
`endif

  // State register and per-state cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic; the counter restarts whenever the state changes.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = reject_s ? ST_REJECT : ST_SELECT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SELECT: next_state_s = ST_SHIFT;
      ST_SHIFT: begin
        if (cnt_r == SHIFT_LAST) begin
          next_state_s = (op_r == 2'b11) ? ST_TURN : ST_GAP;
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      ST_TURN:    next_state_s = (cnt_r == TURN_LAST) ? ST_CAPTURE : ST_TURN;
      ST_CAPTURE: next_state_s = (cnt_r == CAP_LAST) ? ST_GAP : ST_CAPTURE;
      ST_GAP:     next_state_s = (cnt_r == GAP_LAST) ? ST_IDLE : ST_GAP;
      ST_REJECT:  next_state_s = ST_IDLE;
      default:    next_state_s = ST_IDLE;
    endcase
    if (next_state_s != state_r) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  // Output decode from the upcoming state so every pin leaves a flop.
  always_comb begin
    ss_n_s      = 1'b1;
    mosi_s      = 1'b0;
    rsp_valid_s = 1'b0;
    cmd_ready_s = (next_state_s == ST_IDLE);
    busy_s      = (next_state_s != ST_IDLE);
    case (next_state_s)
      ST_SELECT: begin
        ss_n_s = 1'b0;
        mosi_s = host.cmd_data[9];
      end
      ST_SHIFT: begin
        ss_n_s = 1'b0;
        mosi_s = shift_r[9];
      end
      ST_TURN:    ss_n_s = 1'b0;
      ST_CAPTURE: ss_n_s = 1'b0;
      ST_GAP:     rsp_valid_s = (state_r == ST_CAPTURE);
      default:    ss_n_s = 1'b1;
    endcase
  end

  // Command shift register and MISO capture path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r    <= 10'h000;
      op_r       <= 2'b00;
      cap_r      <= 7'h00;
      rsp_data_r <= 8'h00;
    end else begin
      if (accept_s) begin
        shift_r <= host.cmd_data;
        op_r    <= host.cmd_data[9:8];
      end else if (next_state_s == ST_SHIFT) begin
        shift_r <= {shift_r[8:0], 1'b0};
      end
      if (state_r == ST_CAPTURE) begin
        cap_r <= {cap_r[5:0], MISO};
      end
      if (cap_done_s) begin
        rsp_data_r <= {cap_r, MISO};
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_n_r      <= 1'b1;
      mosi_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      ss_n_r      <= ss_n_s;
      mosi_r      <= mosi_s;
      cmd_ready_r <= cmd_ready_s;
      rsp_valid_r <= rsp_valid_s;
      busy_r      <= busy_s;
    end
  end

  assign SS_n           = ss_n_r;
  assign MOSI           = mosi_r;
  assign host.cmd_ready = cmd_ready_r;
  assign host.rsp_valid = rsp_valid_r;
  assign host.rsp_data  = rsp_data_r;
  assign host.busy      = busy_r;

endmodule

// File: doc/spi_ram_master.md
Name: spi_ram_master

Overview:
- Upstream SPI master that drives the SPI-slave/single-port-RAM subsystem over SS_n/MOSI/MISO.
- Accepts 10-bit command words from a host-side valid/ready interface and serialises each one as a single SPI frame.
- For read-data commands (cmd[9:8]=2'b11), captures the 8-bit RAM byte returned on MISO and presents it on a one-cycle response strobe.
- The SPI clock is the system clock: MOSI changes and MISO is sampled on clk rising edges.

Parameters:
- TURNAROUND, 2, clk cycles SS_n is held low between the last MOSI bit and the first MISO sample of a read-data frame (minimum 1).
- IDLE_GAP, 1, clk cycles SS_n is held high after each frame before the next command is accepted (minimum 1).

Ports:
- clk  in  1  system clock; also serves as the SPI clock.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  host command present.
- cmd_data  in  10  command word: [9:8] opcode (00 write address, 01 write data, 10 read address, 11 read data), [7:0] payload.
- cmd_ready  out  1  master can accept a command.
- rsp_valid  out  1  one-cycle strobe, rsp_data valid.
- rsp_data  out  8  byte captured from MISO.
- busy  out  1  high while a frame or inter-frame gap is in progress.
- SS_n  out  1  slave select, active-low.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; SS_n=1; MOSI=0; cmd_ready=1; rsp_valid=0; rsp_data=8'h00; busy=0; all counters=0.
- Handshake:
  - A command is accepted on a clk edge with cmd_valid&&cmd_ready. cmd_data is latched into a shift register.
  - cmd_ready=1 only in IDLE. cmd_data is ignored at all other times.
- State machine (one state per clk unless noted):
  - IDLE: SS_n=1, MOSI=0. On accept -> SELECT.
  - SELECT, 1 cycle: SS_n=0, MOSI=cmd[9]. This is the slave's read/write-select bit. -> SHIFT.
  - SHIFT, 10 cycles: SS_n=0, MOSI=cmd[9], cmd[8], ..., cmd[0], MSB first, one bit per cycle.
    - After bit 0: if opcode==2'b11 -> TURN; else -> GAP.
  - TURN, TURNAROUND cycles: SS_n=0, MOSI=0. -> CAPTURE.
  - CAPTURE, 8 cycles: SS_n=0. MISO is sampled at the end of each cycle into rsp_data, MSB first. After the 8th sample -> GAP.
  - GAP, IDLE_GAP cycles: SS_n=1, MOSI=0. -> IDLE.
    - On entering GAP from CAPTURE, rsp_valid=1 for exactly that one cycle with the full byte.
- Frame length: non-read frame = 11 cycles SS_n low. Read-data frame = 11+TURNAROUND+8 cycles SS_n low.
- Latency: cmd accept edge to rsp_valid = 1+10+TURNAROUND+8 cycles (21 at defaults).
- Throughput: back-to-back commands are separated by at least IDLE_GAP+1 cycles of SS_n high (the IDLE cycle is included).
- busy=1 in every state except IDLE.
- rsp_data holds its last value until the next capture. It is never cleared except by reset.
- Reset mid-frame: SS_n goes high immediately (asynchronously), the frame is abandoned, no rsp_valid is produced, and the master returns to IDLE.
- cmd_valid asserted during busy: no effect. The host must hold the command until cmd_ready.
- MISO is not sampled outside CAPTURE.

Optional Feature:
- Macro: SPI_RAM_MASTER_SEQCHK_EN.
- Defined:
  - Adds output seq_err (1 bit, reset 0) and an internal flag rd_addr_set (reset 0).
  - rd_addr_set is set when a 2'b10 frame completes and cleared when a 2'b11 frame completes.
  - A 2'b11 command accepted while rd_addr_set=0 is rejected: no SPI frame (SS_n stays high), seq_err=1 for one cycle, state returns to IDLE on the next cycle. cmd_ready is low for that one cycle.
- Not defined: no seq_err port; every opcode is framed unconditionally.

Test Plan:
- Reset: assert rst mid-SHIFT of cmd 10'h0A5 -> SS_n=1 within the same cycle, cmd_ready=1, rsp_valid never pulses, MOSI=0.
- Write address: cmd_data=10'h03C -> SS_n low for exactly 11 cycles, MOSI sequence 0,0,0,0,0,1,1,1,1,0,0, then SS_n high for IDLE_GAP cycles; no rsp_valid.
- Write data: cmd_data=10'h15A after the write-address frame -> MOSI 0 then 0,1,0,1,0,1,1,0,1,0; the slave's RAM model shows mem[8'h3C]=8'h5A.
- Read sequence: 10'h23C then 10'h300 -> second frame holds SS_n low 21 cycles; rsp_valid pulses once with rsp_data=8'h5A exactly 21 cycles after accept.
- Back-to-back: cmd_valid held high with four queued commands -> each accepted only when cmd_ready=1, gaps of SS_n high >= IDLE_GAP cycles, no dropped or duplicated frames.
- With SPI_RAM_MASTER_SEQCHK_EN: 10'h300 issued right after reset -> SS_n stays 1, seq_err pulses one cycle, no rsp_valid. A subsequent 10'h200, 10'h300 pair completes normally.
